// File: rtl/bsg_pending_dispatch.sv
// Sticky request accumulator feeding a lowest-index-first priority encoder,
// with a one-entry valid/yumi output stage that dispatches one index per cycle.

module bsg_pending_dispatch_encode #(
  parameter int width_p    = 16,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]    i,
  output logic [lg_width_p-1:0] addr_o,
  output logic                  v_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    addr_o = '0;
    v_o    = |i;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (i[k]) addr_o = lg_width_p'(k);
    end
  end

endmodule

module bsg_pending_dispatch #(
  parameter int width_p    = 16,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [width_p-1:0]    set_i,
  output logic                  v_o,
  output logic [lg_width_p-1:0] addr_o,
  input  logic                  yumi_i,
  output logic [width_p-1:0]    pending_o,
  output logic                  overflow_o
);

  logic [width_p-1:0]    pending_r;
  logic [width_p-1:0]    pending_next;
  logic                  v_r;
  logic                  v_next;
  logic [lg_width_p-1:0] addr_r;
  logic [lg_width_p-1:0] addr_next;
  logic                  overflow_r;
  logic                  overflow_next;

  logic [lg_width_p-1:0] sel_idx;
  logic                  sel_v;
  logic                  load;
  logic [width_p-1:0]    clr_mask;
  logic                  dup;

  // Only registered state feeds the encoder, never set_i directly.
  bsg_pending_dispatch_encode #(
    .width_p   (width_p),
    .lg_width_p(lg_width_p)
  ) encode (
    .i     (pending_r),
    .addr_o(sel_idx),
    .v_o   (sel_v)
  );

  // Refill on the same cycle the consumer takes the current entry.
  assign load = sel_v & (~v_r | yumi_i);

  for (genvar gi = 0; gi < width_p; gi++) begin : g_clr
    assign clr_mask[gi] = load & (sel_idx == lg_width_p'(gi));
  end

  assign dup = |(set_i & pending_r & ~clr_mask);

  always_comb begin
    pending_next  = (pending_r & ~clr_mask) | set_i;
    overflow_next = overflow_r | dup;
    v_next        = v_r;
    addr_next     = addr_r;
    if (load) begin
      v_next    = 1'b1;
      addr_next = sel_idx;
    end else if (yumi_i) begin
      v_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_r  <= '0;
      v_r        <= 1'b0;
      addr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_next;
      v_r        <= v_next;
      addr_r     <= addr_next;
      overflow_r <= overflow_next;
    end
  end

  // A yumi with nothing presented is a consumer protocol error.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_r));
    end
  end

  assign v_o        = v_r;
  assign addr_o     = addr_r;
  assign pending_o  = pending_r;
  assign overflow_o = overflow_r;

endmodule

// File: doc/bsg_pending_dispatch.md
Name: bsg_pending_dispatch

Overview:
- Sequential front end for the 16-bit lowest-index-first priority encoder.
- Accumulates single-cycle request pulses into a sticky pending vector and selects the lowest pending index with that encoder.
- Registers the selected index in a one-entry output stage with a valid/yumi handshake, then clears the dispatched bit.
- Used as an interrupt or request dispatcher ahead of a single-issue consumer.

Parameters:
- width_p, 16, number of request lines; must be a power of 2 and at least 2.
- lg_width_p, $clog2(width_p), width of addr_o; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- set_i  in  width_p  request pulses; bit k high sets pending bit k.
- v_o  out  1  output stage holds a valid index.
- addr_o  out  lg_width_p  dispatched index; meaningful only when v_o=1.
- yumi_i  in  1  consumer takes addr_o this cycle; legal only when v_o=1.
- pending_o  out  width_p  current pending vector (pending_r), registered.
- overflow_o  out  1  sticky flag: a request was merged into an already-pending bit.

Behaviour:
- State: pending_r[width_p], v_r, addr_r[lg_width_p], overflow_r.
- Reset is asynchronous and active-high: pending_r=0, v_r=0, addr_r=0, overflow_r=0 immediately.
  - v_o, addr_o, pending_o and overflow_o all read 0 during reset and on the first edge after release.
  - Reset mid-operation discards all pending and presented requests; no partial state survives.
- Encoder input is pending_r only, never set_i directly. This keeps timing registered-to-registered.
  - sel_v = |pending_r.
  - sel_idx = lowest set index of pending_r.
- load = sel_v & (~v_r | yumi_i). The output stage refills on the same cycle it is consumed, giving full throughput of one dispatch per cycle.
- clr_mask = load ? one-hot(sel_idx) : 0.
- pending_r next = (pending_r & ~clr_mask) | set_i. Set wins over clear on the same bit in the same cycle.
- Output stage next:
  - if load: v_r=1, addr_r=sel_idx.
  - else if yumi_i: v_r=0, addr_r holds.
  - else: hold.
- Stability: while v_o=1 and yumi_i=0, addr_o does not change.
- Latency: set_i pulse at cycle t with the pipeline idle gives pending_o bit at t+1 and v_o=1 with that addr_o at t+2.
- Duplicate detection: dup = |(set_i & pending_r & ~clr_mask).
  - if dup: overflow_r <= 1. Sticky until reset.
  - The duplicate request is merged; there is no extra dispatch.
- Setting a bit equal to the currently presented addr_o is not a duplicate. That bit was already removed from pending, so it is queued as a new request.
- yumi_i while v_o=0 is illegal. The RTL ignores it (no state change) and fires a simulation assertion.
- All-zero set_i with empty pending: v_o stays 0. addr_o holds its last value and is don't-care.
- Ordering is strictly lowest index first among bits present in pending_r at the load cycle. High indices can starve under sustained low-index traffic; this is accepted by design.
- Internally instantiates the existing priority encoder on pending_r, using its addr_o and v_o. No other arithmetic.
- Implementation is 120-200 lines of RTL.

Test Plan:
- Reset check: assert reset_i mid-cycle with pending_r=16'h00F0 and v_o=1 -> all outputs read 0 immediately (asynchronous). After release, no dispatch occurs without new set_i.
- Single request: set_i=16'h0020 for one cycle at t, yumi_i=1 whenever v_o -> pending_o=16'h0020 at t+1, then v_o=1 with addr_o=5 at t+2, then v_o=0 at t+3.
- Multi-request ordering: set_i=16'h8421 in one cycle, yumi_i held 1 -> addr_o sequence 0,5,10,15 on four consecutive cycles, then v_o=0 and pending_o=0.
- Backpressure: set_i=16'h0006, yumi_i=0 for 5 cycles -> v_o=1 and addr_o=1 stable throughout, pending_o=16'h0004. Raising yumi_i for 2 cycles -> addr_o 1 then 2.
- Duplicate/overflow: set_i=16'h0100 twice while bit 8 is pending and not yet loaded -> overflow_o=1 sticky, exactly one dispatch of addr_o=8. Separately, setting bit 3 while addr_o=3 is presented and yumi_i=0 -> no overflow, and a second dispatch of 3 occurs later.
- Same-cycle set and clear: pending_r=16'h0001 and set_i=16'h0001 on the cycle bit 0 is loaded -> pending_o bit 0 remains 1, overflow_o stays 0, and index 0 is dispatched twice.
